// File: rtl/unary_op_engine.sv
// Multi-cycle single-operand engine: a register file plus a four-state
// IDLE/DECODE/EXEC/WRITE sequencer that applies one unary op per instruction.
module unary_op_engine #(
  parameter int WIDTH  = 32,
  parameter int NREG   = 32,
  parameter int SAT_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instruction,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [WIDTH-1:0] out,
  output logic             sys_dne,
  output logic             ovf,
  output logic             err,
  input  logic [4:0]       dbg_idx,
  output logic [WIDTH-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WRITE} state_t;

  localparam logic signed [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [WIDTH-1:0] ONE_V = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t                  r_state, w_state_nxt;
  logic [31:0]             r_instr_p0;
  logic signed [WIDTH-1:0] r_opnd_p1;
  logic signed [WIDTH-1:0] r_out;
  logic                    r_ovf_p2, r_err_p2, r_dne;
  logic signed [WIDTH-1:0] r_rf [NREG];

  logic [3:0]              w_op;
  logic                    w_sat;
  logic [4:0]              w_dst, w_src;
  logic [16:0]             w_imm;
  logic                    w_bad_idx;
  logic signed [WIDTH-1:0] w_res, w_neg, w_dbl;
  logic                    w_neg_ovf, w_ovf, w_err;

  function automatic logic signed [WIDTH-1:0] sat_sel(
    input logic sat, input logic signed [WIDTH-1:0] sat_val,
    input logic signed [WIDTH-1:0] wrap_val);
    return sat ? sat_val : wrap_val;
  endfunction

  function automatic logic signed [WIDTH-1:0] imm_ext(input logic [16:0] imm);
    logic [WIDTH+16:0] t;
    t = {{WIDTH{1'b0}}, imm};
    return t[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] rf_rd(input logic [4:0] idx);
    logic signed [WIDTH-1:0] v;
    v = '0;
    for (int i = 0; i < NREG; i++)
      if (i == int'(idx)) v = r_rf[i];
    return v;
  endfunction

  assign w_op      = r_instr_p0[31:28];
  assign w_sat     = (SAT_EN != 0) && r_instr_p0[27];
  assign w_dst     = r_instr_p0[26:22];
  assign w_src     = r_instr_p0[21:17];
  assign w_imm     = r_instr_p0[16:0];
  assign w_bad_idx = (int'(w_dst) >= NREG) || (int'(w_src) >= NREG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (instr_valid) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = S_WRITE;
      S_WRITE:  w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // EXEC stage: result, overflow and error from the latched operand
  always_comb begin
    w_neg     = -r_opnd_p1;
    w_neg_ovf = (r_opnd_p1 == MIN_V);
    if (w_neg_ovf) w_neg = sat_sel(w_sat, MAX_V, MIN_V);
    w_dbl = r_opnd_p1 <<< 1;
    w_res = r_out;
    w_ovf = 1'b0;
    w_err = 1'b0;
    case (w_op)
      4'd0: w_res = imm_ext(w_imm);
      4'd1: begin w_res = w_neg; w_ovf = w_neg_ovf; end
      4'd2: begin
        w_ovf = (r_opnd_p1 == MAX_V);
        w_res = w_ovf ? sat_sel(w_sat, MAX_V, MIN_V) : r_opnd_p1 + ONE_V;
      end
      4'd3: begin
        w_ovf = (r_opnd_p1 == MIN_V);
        w_res = w_ovf ? sat_sel(w_sat, MIN_V, MAX_V) : r_opnd_p1 - ONE_V;
      end
      4'd4: begin
        w_ovf = r_opnd_p1[WIDTH-1] ^ r_opnd_p1[WIDTH-2];
        w_res = w_ovf ? sat_sel(w_sat, r_opnd_p1[WIDTH-1] ? MIN_V : MAX_V, w_dbl) : w_dbl;
      end
      4'd5: w_res = r_opnd_p1 >>> 1;
      4'd6: begin
        w_res = r_opnd_p1[WIDTH-1] ? w_neg : r_opnd_p1;
        w_ovf = w_neg_ovf;
      end
      default: w_err = 1'b1;
    endcase
    if (w_bad_idx) w_err = 1'b1;
    if (w_err) begin
      w_ovf = 1'b0;
      w_res = r_out;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr_p0 <= '0;
      r_opnd_p1  <= '0;
      r_out      <= '0;
      r_ovf_p2   <= 1'b0;
      r_err_p2   <= 1'b0;
      r_dne      <= 1'b0;
    end else begin
      r_dne <= (r_state == S_WRITE);
      if (r_state == S_IDLE && instr_valid) r_instr_p0 <= instruction;
      // DECODE stage: capture the source operand
      if (r_state == S_DECODE) r_opnd_p1 <= rf_rd(w_src);
      if (r_state == S_EXEC) begin
        r_out    <= w_res;
        r_ovf_p2 <= w_ovf;
        r_err_p2 <= w_err;
      end
    end
  end

  // WRITE stage: commit the registered result unless the instruction was illegal
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) r_rf[i] <= '0;
    end else if (r_state == S_WRITE && !r_err_p2) begin
      for (int i = 0; i < NREG; i++)
        if (i == int'(w_dst)) r_rf[i] <= r_out;
    end
  end

  assign instr_ready = (r_state == S_IDLE);
  assign out         = r_out;
  assign sys_dne     = r_dne;
  assign ovf         = r_dne & r_ovf_p2;
  assign err         = r_dne & r_err_p2;
  assign dbg_data    = rf_rd(dbg_idx);

endmodule

// File: tb/tb_unary_op_engine.sv
// Directed bench for unary_op_engine: default 32-entry instance plus a
// 16-entry instance for out-of-range register indices.
module tb_unary_op_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        instr_valid, v16;
  logic        instr_ready, rdy16;
  logic [31:0] out, out16;
  logic        sys_dne, dne16, ovf, ovf16, err, err16;
  logic [4:0]  dbg_idx, dbg16_idx;
  logic [31:0] dbg_data, dbg16_data;

  int n_cmp = 0;
  int n_mis = 0;
  int lat;
  logic got_ovf, got_err;

  always #5 clk = ~clk;

  unary_op_engine #(.WIDTH(32), .NREG(32), .SAT_EN(1)) u_dut (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .out(out), .sys_dne(sys_dne), .ovf(ovf), .err(err),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data));

  unary_op_engine #(.WIDTH(32), .NREG(16), .SAT_EN(1)) u_dut16 (
    .clk(clk), .reset(reset), .instruction(instruction), .instr_valid(v16),
    .instr_ready(rdy16), .out(out16), .sys_dne(dne16), .ovf(ovf16), .err(err16),
    .dbg_idx(dbg16_idx), .dbg_data(dbg16_data));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [3:0] op, input logic sat,
                                     input logic [4:0] dst, input logic [4:0] src,
                                     input logic [16:0] imm);
    return {op, sat, dst, src, imm};
  endfunction

  task automatic issue(input logic [3:0] op, input logic sat, input logic [4:0] dst,
                       input logic [4:0] src, input logic [16:0] imm);
    @(negedge clk);
    instruction = mk(op, sat, dst, src, imm);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instruction = $urandom;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (!sys_dne && lat < 8);
    got_ovf = ovf;
    got_err = err;
  endtask

  task automatic op_chk(input string tag, input logic [3:0] op, input logic sat,
                        input logic [4:0] dst, input logic [4:0] src, input logic [16:0] imm,
                        input logic [31:0] exp_v, input logic exp_ovf);
    issue(op, sat, dst, src, imm);
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_ovf"}, got_ovf, exp_ovf);
    chk({tag, "_err"}, got_err, 1'b0);
    chk({tag, "_out"}, out, exp_v);
    dbg_idx = dst; #1;
    chk({tag, "_reg"}, dbg_data, exp_v);
  endtask

  task automatic issue16(input string tag, input logic [31:0] ins, input logic exp_err,
                         input logic [4:0] idx, input logic [31:0] exp_reg);
    int n;
    @(negedge clk);
    instruction = ins;
    v16 = 1'b1;
    @(posedge clk); #1;
    v16 = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!dne16 && n < 8);
    chk({tag, "_lat"}, 64'(n), 64'd3);
    chk({tag, "_err"}, err16, exp_err);
    dbg16_idx = idx; #1;
    chk({tag, "_reg"}, dbg16_data, exp_reg);
  endtask

  initial begin
    int n;
    int dne_cnt;
    reset = 1'b0;
    instruction = '0;
    instr_valid = 1'b0;
    v16 = 1'b0;
    dbg_idx = 5'd5;
    dbg16_idx = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 32'h0);
    chk("rst_dne", sys_dne, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_ready", instr_ready, 1'b1);
    chk("rst_reg", dbg_data, 32'h0);
    @(negedge clk) reset = 1'b1;

    op_chk("loadi23", 4'd0, 1'b0, 5'd23, 5'd0, 17'd16782, 32'h0000418E, 1'b0);
    op_chk("neg23",   4'd1, 1'b0, 5'd23, 5'd23, 17'd0, 32'hFFFFBE72, 1'b0);
    op_chk("ld1408",  4'd0, 1'b0, 5'd23, 5'd0, 17'd1408, 32'h00000580, 1'b0);
    op_chk("dbl",     4'd4, 1'b0, 5'd23, 5'd23, 17'd0, 32'h00000B00, 1'b0);
    op_chk("neg",     4'd1, 1'b0, 5'd23, 5'd23, 17'd0, 32'hFFFFF500, 1'b0);
    op_chk("halve",   4'd5, 1'b0, 5'd23, 5'd23, 17'd0, 32'hFFFFFA80, 1'b0);
    op_chk("abs",     4'd6, 1'b1, 5'd9,  5'd23, 17'd0, 32'h00000580, 1'b0);

    // Build 0x80000000 in r2 by doubling 2^16 fifteen times.
    issue(4'd0, 1'b0, 5'd2, 5'd0, 17'h10000);
    for (int i = 0; i < 14; i++) issue(4'd4, 1'b0, 5'd2, 5'd2, 17'd0);
    op_chk("dbl_wrap",    4'd4, 1'b0, 5'd2,  5'd2, 17'd0, 32'h80000000, 1'b1);
    op_chk("dec_wrap",    4'd3, 1'b0, 5'd1,  5'd2, 17'd0, 32'h7FFFFFFF, 1'b1);
    op_chk("inc_sat",     4'd2, 1'b1, 5'd3,  5'd1, 17'd0, 32'h7FFFFFFF, 1'b1);
    op_chk("inc_wrap",    4'd2, 1'b0, 5'd4,  5'd1, 17'd0, 32'h80000000, 1'b1);
    op_chk("neg_sat",     4'd1, 1'b1, 5'd5,  5'd2, 17'd0, 32'h7FFFFFFF, 1'b1);
    op_chk("abs_wrap",    4'd6, 1'b0, 5'd6,  5'd2, 17'd0, 32'h80000000, 1'b1);
    op_chk("dec_sat",     4'd3, 1'b1, 5'd7,  5'd2, 17'd0, 32'h80000000, 1'b1);
    op_chk("dbl_sat_pos", 4'd4, 1'b1, 5'd8,  5'd1, 17'd0, 32'h7FFFFFFF, 1'b1);
    op_chk("dbl_sat_neg", 4'd4, 1'b1, 5'd10, 5'd4, 17'd0, 32'h80000000, 1'b1);
    op_chk("neg_wrap",    4'd1, 1'b0, 5'd11, 5'd2, 17'd0, 32'h80000000, 1'b1);
    op_chk("inc_norm",    4'd2, 1'b1, 5'd14, 5'd9, 17'd0, 32'h00000581, 1'b0);
    op_chk("dec_norm",    4'd3, 1'b1, 5'd15, 5'd9, 17'd0, 32'h0000057F, 1'b0);
    op_chk("r0_write",    4'd0, 1'b0, 5'd0,  5'd0, 17'd99, 32'h00000063, 1'b0);

    // Illegal op with instr_valid held: next accept lands in the sys_dne cycle.
    @(negedge clk);
    instruction = mk(4'd9, 1'b0, 5'd23, 5'd23, 17'd5);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instruction = mk(4'd0, 1'b0, 5'd12, 5'd0, 17'd77);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!sys_dne && n < 8);
    chk("ill_lat", 64'(n), 64'd3);
    chk("ill_err", err, 1'b1);
    chk("ill_ovf", ovf, 1'b0);
    chk("ill_ready", instr_ready, 1'b1);
    chk("ill_out", out, 32'h00000063);
    dbg_idx = 5'd23; #1;
    chk("ill_reg", dbg_data, 32'hFFFFFA80);
    @(posedge clk); #1;
    chk("b2b_ready", instr_ready, 1'b0);
    chk("b2b_dne", sys_dne, 1'b0);
    instr_valid = 1'b0;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!sys_dne && n < 8);
    chk("b2b_lat", 64'(n), 64'd3);
    chk("b2b_err", err, 1'b0);
    dbg_idx = 5'd12; #1;
    chk("b2b_reg", dbg_data, 32'd77);

    // Out-of-range indices on the 16-entry instance.
    issue16("n16_ok",  mk(4'd0, 1'b0, 5'd3, 5'd0, 17'd5), 1'b0, 5'd3, 32'd5);
    issue16("n16_dst", mk(4'd0, 1'b0, 5'd20, 5'd0, 17'd7), 1'b1, 5'd20, 32'd0);
    chk("n16_out", out16, 32'd5);
    issue16("n16_src", mk(4'd1, 1'b0, 5'd3, 5'd20, 17'd0), 1'b1, 5'd3, 32'd5);

    // Reset while the instruction sits in EXEC.
    @(negedge clk);
    instruction = mk(4'd0, 1'b0, 5'd13, 5'd0, 17'd555);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_exec_ready", instr_ready, 1'b1);
    chk("rst_exec_dne", sys_dne, 1'b0);
    chk("rst_exec_out", out, 32'h0);
    @(negedge clk) reset = 1'b1;
    dne_cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (sys_dne) dne_cnt++; end
    chk("rst_exec_nodne", 64'(dne_cnt), 64'd0);
    dbg_idx = 5'd13; #1;
    chk("rst_exec_r13", dbg_data, 32'h0);
    dbg_idx = 5'd23; #1;
    chk("rst_exec_r23", dbg_data, 32'h0);
    op_chk("post_rst", 4'd0, 1'b0, 5'd13, 5'd0, 17'd555, 32'd555, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
